game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
// Parametrised top-level game-flow FSM; successor to the 3-state menu/game/pause controller.
// Adds platform-load, game-over and restart flow, edge-qualified keys (held keys never re-fire),
// a frame-timed game-over hold and a round counter. Sits between USB keycode decode and
// the platform generator, physics and sprite/screen-select logic.
// PARAMETERS
// KEY_START       8'd44   keycode that starts from MENU (space)
// KEY_PAUSE       8'd41   keycode that pauses from PLAY (esc)
// KEY_RESTART     8'd21   keycode that restarts from GAMEOVER ('R')
// LOAD_CYCLES     4       clocks loadplat stays high in LOAD (>=1)
// GAMEOVER_FRAMES 180     frame_tick count before GAMEOVER auto-returns to MENU (>=1)
// ROUND_W         8       width of round_cnt
// PORTS
// Clock       in   1        system clock
// Reset       in   1        asynchronous, active-high reset
// Keycode     in   8        current keycode from keyboard interface, 0 = none
// frame_tick  in   1        one-clock pulse per video frame
// player_dead in   1        level from physics: player fell off screen
// outstate    out  3        screen select: MENU=000 PLAY=001 PAUSE=010 LOAD=011 GAMEOVER=100
// loadplat    out  1        platform-generator load strobe
// score_clr   out  1        one-clock score clear pulse
// game_run    out  1        physics/scroll enable, high only in PLAY
// round_cnt   out  ROUND_W  rounds started since reset, saturating
// BEHAVIOUR
// - Reset (async, active-high): state=MENU, key_q=0, load/hold counters=0, round_cnt=0;
//   outputs outstate=000, loadplat=0, score_clr=0, game_run=0. Reset mid-round aborts immediately.
// - Key event: key_ev = (Keycode!=0) && (Keycode!=key_q); key_q <= Keycode every clock.
//   A key held across states fires once; a key held through reset release fires once.
// - All outputs Moore, decoded from registered state/counters; transitions take effect next clock.
// - MENU: key_ev && Keycode==KEY_START -> LOAD. Other keys ignored.
// - LOAD: loadplat=1 every cycle in LOAD; score_clr=1 on the first LOAD cycle only;
//   round_cnt increments (saturates at all-ones) on entry. After exactly LOAD_CYCLES cycles -> PLAY.
//   Keys and player_dead ignored in LOAD.
// - PLAY: game_run=1. player_dead -> GAMEOVER; else key_ev && KEY_PAUSE -> PAUSE.
//   Same-cycle player_dead and pause: GAMEOVER wins.
// - PAUSE: game_run=0; any key_ev (incl. KEY_PAUSE) -> PLAY; player_dead ignored.
// - GAMEOVER: hold counter cleared on entry, +1 per frame_tick.
//   key_ev && KEY_RESTART -> LOAD (new round); else counter==GAMEOVER_FRAMES -> MENU.
//   Restart and timeout on same cycle: restart wins.
// - Load counter width $clog2(LOAD_CYCLES+1), hold counter $clog2(GAMEOVER_FRAMES+1); no wrap.
// - Illegal state encoding recovers to MENU next clock.
// STRUCTURE
// - doodle_pkg: game_state_e enum (5 states), OUTSTATE_* 3-bit constants, KEY_SPACE/KEY_ESC/KEY_R.
// - Sub-module key_edge_det (Clock, Reset, Keycode -> key_ev, key_val); rest is one FSM + 2 counters.
// TESTING
// - Reset, Keycode=0 100 clocks -> outstate=000, all strobes 0, round_cnt=0.
// - Keycode=44 held 50 clocks -> loadplat high exactly 4 clocks, score_clr 1 clock,
//   outstate 011 then 001, round_cnt=1, game_run=1; stays PLAY.
// - PLAY, Keycode=41 held 20 clocks -> PAUSE only (no bounce); release, press 'A'(4) -> PLAY.
// - PLAY, player_dead and Keycode=41 edge same clock -> outstate=100; 180 frame_ticks -> 000.
// - GAMEOVER, Keycode=21 after 10 frame_ticks -> LOAD, round_cnt=2; restart on timeout tick -> LOAD.
// - Reset asserted mid-LOAD asynchronously -> loadplat=0 and outstate=000 before next edge.

Source files
------------

// File: rtl/doodle_pkg.sv
// Shared types and constants for the game-flow controller: state encoding,
// screen-select codes and the default keycodes.
package doodle_pkg;

   typedef enum logic [2:0] {
      ST_MENU     = 3'b000,
      ST_PLAY     = 3'b001,
      ST_PAUSE    = 3'b010,
      ST_LOAD     = 3'b011,
      ST_GAMEOVER = 3'b100
   } game_state_e;

   localparam logic [2:0] OUTSTATE_MENU     = 3'b000;
   localparam logic [2:0] OUTSTATE_PLAY     = 3'b001;
   localparam logic [2:0] OUTSTATE_PAUSE    = 3'b010;
   localparam logic [2:0] OUTSTATE_LOAD     = 3'b011;
   localparam logic [2:0] OUTSTATE_GAMEOVER = 3'b100;

   localparam logic [7:0] KEY_NONE  = 8'd0;
   localparam logic [7:0] KEY_SPACE = 8'd44;
   localparam logic [7:0] KEY_ESC   = 8'd41;
   localparam logic [7:0] KEY_R     = 8'd21;

   // Unknown encodings map to the menu screen so a corrupted state never selects garbage.
   function automatic logic [2:0] state_to_outstate(input game_state_e s);
      logic [2:0] o;
      case (s)
         ST_MENU:     o = OUTSTATE_MENU;
         ST_PLAY:     o = OUTSTATE_PLAY;
         ST_PAUSE:    o = OUTSTATE_PAUSE;
         ST_LOAD:     o = OUTSTATE_LOAD;
         ST_GAMEOVER: o = OUTSTATE_GAMEOVER;
         default:     o = OUTSTATE_MENU;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/key_edge_det.sv
// Keycode edge qualifier: fires key_ev only on the first clock a non-zero
// keycode differs from the previous clock's keycode, so held keys never re-fire.
module key_edge_det
   import doodle_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] Keycode,
   output logic       key_ev,
   output logic [7:0] key_val
);

   logic [7:0] key_q;
   logic [7:0] key_d;

   // Previous-keycode register; cleared by reset so a key held through reset fires once.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         key_q <= KEY_NONE;
      end else begin
         key_q <= key_d;
      end
   end

   // Edge decode against the previous keycode.
   always_comb begin
      key_d   = Keycode;
      key_val = Keycode;
      key_ev  = (Keycode != KEY_NONE) && (Keycode != key_q);
   end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game-flow FSM: menu, platform load, play, pause and game-over with
// a frame-timed hold, plus a saturating round counter. All outputs are registered.
module game_flow_ctrl
   import doodle_pkg::*;
#(
   parameter logic [7:0]  KEY_START       = KEY_SPACE,
   parameter logic [7:0]  KEY_PAUSE       = KEY_ESC,
   parameter logic [7:0]  KEY_RESTART     = KEY_R,
   parameter int unsigned LOAD_CYCLES     = 4,
   parameter int unsigned GAMEOVER_FRAMES = 180,
   parameter int unsigned ROUND_W         = 8
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [7:0]         Keycode,
   input  logic               frame_tick,
   input  logic               player_dead,
   output logic [2:0]         outstate,
   output logic               loadplat,
   output logic               score_clr,
   output logic               game_run,
   output logic [ROUND_W-1:0] round_cnt
);

   localparam int unsigned LOAD_W = $clog2(LOAD_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(GAMEOVER_FRAMES + 1);
   localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(GAMEOVER_FRAMES);

   logic        key_ev;
   logic [7:0]  key_val;

   game_state_e         state_q, state_d;
   logic [LOAD_W-1:0]   load_cnt_q, load_cnt_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [ROUND_W-1:0]  round_cnt_q, round_cnt_d;
   logic [2:0]          outstate_q, outstate_d;
   logic                loadplat_q, loadplat_d;
   logic                score_clr_q, score_clr_d;
   logic                game_run_q, game_run_d;

   key_edge_det u_key_edge_det (
      .Clock   (Clock),
      .Reset   (Reset),
      .Keycode (Keycode),
      .key_ev  (key_ev),
      .key_val (key_val)
   );

   // State, counters and output registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_MENU;
         load_cnt_q  <= '0;
         hold_cnt_q  <= '0;
         round_cnt_q <= '0;
         outstate_q  <= OUTSTATE_MENU;
         loadplat_q  <= 1'b0;
         score_clr_q <= 1'b0;
         game_run_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         round_cnt_q <= round_cnt_d;
         outstate_q  <= outstate_d;
         loadplat_q  <= loadplat_d;
         score_clr_q <= score_clr_d;
         game_run_q  <= game_run_d;
      end
   end

   // Next-state and counter logic; counters idle at zero outside their own state.
   always_comb begin
      state_d    = state_q;
      load_cnt_d = '0;
      hold_cnt_d = '0;
      case (state_q)
         ST_MENU: begin
            if (key_ev && (key_val == KEY_START)) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_MENU;
            end
         end
         ST_LOAD: begin
            if (load_cnt_q == LOAD_LAST) begin
               state_d = ST_PLAY;
            end else begin
               load_cnt_d = load_cnt_q + 1'b1;
            end
         end
         ST_PLAY: begin
            if (player_dead) begin
               state_d = ST_GAMEOVER;
            end else if (key_ev && (key_val == KEY_PAUSE)) begin
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_PAUSE: begin
            if (key_ev) begin
               state_d = ST_PLAY;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_GAMEOVER: begin
            if (frame_tick && (hold_cnt_q != HOLD_DONE)) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q;
            end
            // Restart takes priority over the hold timeout.
            if (key_ev && (key_val == KEY_RESTART)) begin
               state_d    = ST_LOAD;
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_DONE) begin
               state_d    = ST_MENU;
               hold_cnt_d = '0;
            end else begin
               state_d = ST_GAMEOVER;
            end
         end
         default: begin
            state_d = ST_MENU;
         end
      endcase
   end

   // Round counter and registered Moore outputs, decoded from the next state.
   always_comb begin
      round_cnt_d = round_cnt_q;
      if ((state_d == ST_LOAD) && (state_q != ST_LOAD) && (round_cnt_q != {ROUND_W{1'b1}})) begin
         round_cnt_d = round_cnt_q + 1'b1;
      end else begin
         round_cnt_d = round_cnt_q;
      end
      outstate_d  = state_to_outstate(state_d);
      loadplat_d  = (state_d == ST_LOAD);
      score_clr_d = (state_d == ST_LOAD) && (state_q != ST_LOAD);
      game_run_d  = (state_d == ST_PLAY);
   end

   assign outstate  = outstate_q;
   assign loadplat  = loadplat_q;
   assign score_clr = score_clr_q;
   assign game_run  = game_run_q;
   assign round_cnt = round_cnt_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Table-driven bench for game_flow_ctrl: vectors carry inputs and expected outputs,
// expectations flow through a scoreboard queue and are checked after each edge.
module tb_game_flow_ctrl;

   localparam logic [2:0] M  = 3'd0;
   localparam logic [2:0] PL = 3'd1;
   localparam logic [2:0] PA = 3'd2;
   localparam logic [2:0] LD = 3'd3;
   localparam logic [2:0] GO = 3'd4;

   typedef struct {
      logic [7:0] kc;
      logic       ft;
      logic       pd;
      logic [2:0] os;
      logic       lp;
      logic       sc;
      logic       gr;
      logic [7:0] rc;
   } vec_t;

   logic       Clock = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] Keycode = 8'd0;
   logic       frame_tick = 1'b0;
   logic       player_dead = 1'b0;
   logic [2:0] outstate;
   logic       loadplat;
   logic       score_clr;
   logic       game_run;
   logic [7:0] round_cnt;

   int n_cmp = 0;
   int n_fail = 0;
   int vec_idx = 0;
   vec_t vecs[$];
   vec_t exp_q[$];

   game_flow_ctrl dut (
      .Clock       (Clock),
      .Reset       (rst),
      .Keycode     (Keycode),
      .frame_tick  (frame_tick),
      .player_dead (player_dead),
      .outstate    (outstate),
      .loadplat    (loadplat),
      .score_clr   (score_clr),
      .game_run    (game_run),
      .round_cnt   (round_cnt)
   );

   always #5 Clock = ~Clock;

   function automatic vec_t mk(input logic [7:0] kc, input logic ft, input logic pd,
                               input logic [2:0] os, input logic lp, input logic sc,
                               input logic gr, input logic [7:0] rc);
      vec_t v;
      v.kc = kc; v.ft = ft; v.pd = pd;
      v.os = os; v.lp = lp; v.sc = sc; v.gr = gr; v.rc = rc;
      return v;
   endfunction

   task automatic add(input logic [7:0] kc, input logic ft, input logic pd,
                      input logic [2:0] os, input logic lp, input logic sc,
                      input logic gr, input logic [7:0] rc);
      vecs.push_back(mk(kc, ft, pd, os, lp, sc, gr, rc));
   endtask

   // One LOAD sequence (first cycle given by caller) followed by the entry to PLAY.
   task automatic add_load_tail(input logic [7:0] rc);
      for (int i = 0; i < 3; i++) add(8'd0, 1'b0, 1'b0, LD, 1'b1, 1'b0, 1'b0, rc);
      add(8'd0, 1'b0, 1'b0, PL, 1'b0, 1'b0, 1'b1, rc);
   endtask

   task automatic check_out();
      vec_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if ({outstate, loadplat, score_clr, game_run, round_cnt} !==
          {e.os, e.lp, e.sc, e.gr, e.rc}) begin
         n_fail++;
         $display("FAIL vec%0d: got os=%b lp=%b sc=%b gr=%b rc=%0d, expected os=%b lp=%b sc=%b gr=%b rc=%0d",
                  vec_idx, outstate, loadplat, score_clr, game_run, round_cnt,
                  e.os, e.lp, e.sc, e.gr, e.rc);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge Clock);
      Keycode     = v.kc;
      frame_tick  = v.ft;
      player_dead = v.pd;
      exp_q.push_back(v);
      @(posedge Clock);
      #1;
      check_out();
      vec_idx++;
   endtask

   initial begin
      int rc;
      // Idle menu after reset.
      for (int i = 0; i < 100; i++) add(8'd0, 1'b0, 1'b0, M, 1'b0, 1'b0, 1'b0, 8'd0);
      // Start key held 50 clocks: 4 LOAD cycles, then PLAY without re-firing.
      for (int i = 1; i <= 50; i++) begin
         if (i <= 4) add(8'd44, 1'b0, 1'b0, LD, 1'b1, (i == 1), 1'b0, 8'd1);
         else        add(8'd44, 1'b0, 1'b0, PL, 1'b0, 1'b0, 1'b1, 8'd1);
      end
      // Pause held 20 clocks, release, any key resumes.
      for (int i = 0; i < 20; i++) add(8'd41, 1'b0, 1'b0, PA, 1'b0, 1'b0, 1'b0, 8'd1);
      add(8'd0, 1'b0, 1'b0, PA, 1'b0, 1'b0, 1'b0, 8'd1);
      add(8'd4, 1'b0, 1'b0, PL, 1'b0, 1'b0, 1'b1, 8'd1);
      add(8'd0, 1'b0, 1'b0, PL, 1'b0, 1'b0, 1'b1, 8'd1);
      // player_dead ignored while paused.
      add(8'd41, 1'b0, 1'b0, PA, 1'b0, 1'b0, 1'b0, 8'd1);
      for (int i = 0; i < 3; i++) add(8'd0, 1'b0, 1'b1, PA, 1'b0, 1'b0, 1'b0, 8'd1);
      add(8'd4, 1'b0, 1'b0, PL, 1'b0, 1'b0, 1'b1, 8'd1);
      add(8'd0, 1'b0, 1'b0, PL, 1'b0, 1'b0, 1'b1, 8'd1);
      // Death and pause edge together: game over wins; 180 ticks then menu.
      add(8'd41, 1'b0, 1'b1, GO, 1'b0, 1'b0, 1'b0, 8'd1);
      for (int i = 0; i < 180; i++) add(8'd0, 1'b1, 1'b0, GO, 1'b0, 1'b0, 1'b0, 8'd1);
      add(8'd0, 1'b0, 1'b0, M, 1'b0, 1'b0, 1'b0, 8'd1);
      // Round 2: keys and death ignored in LOAD.
      add(8'd44, 1'b0, 1'b0, LD, 1'b1, 1'b1, 1'b0, 8'd2);
      add(8'd41, 1'b0, 1'b0, LD, 1'b1, 1'b0, 1'b0, 8'd2);
      add(8'd0, 1'b0, 1'b1, LD, 1'b1, 1'b0, 1'b0, 8'd2);
      add(8'd0, 1'b0, 1'b0, LD, 1'b1, 1'b0, 1'b0, 8'd2);
      add(8'd0, 1'b0, 1'b0, PL, 1'b0, 1'b0, 1'b1, 8'd2);
      add(8'd0, 1'b0, 1'b1, GO, 1'b0, 1'b0, 1'b0, 8'd2);
      // Restart after 10 ticks.
      for (int i = 0; i < 10; i++) add(8'd0, 1'b1, 1'b0, GO, 1'b0, 1'b0, 1'b0, 8'd2);
      add(8'd21, 1'b0, 1'b0, LD, 1'b1, 1'b1, 1'b0, 8'd3);
      add_load_tail(8'd3);
      add(8'd0, 1'b0, 1'b1, GO, 1'b0, 1'b0, 1'b0, 8'd3);
      // Restart on the timeout cycle wins.
      for (int i = 0; i < 180; i++) add(8'd0, 1'b1, 1'b0, GO, 1'b0, 1'b0, 1'b0, 8'd3);
      add(8'd21, 1'b0, 1'b0, LD, 1'b1, 1'b1, 1'b0, 8'd4);
      add_load_tail(8'd4);
      add(8'd0, 1'b0, 1'b1, GO, 1'b0, 1'b0, 1'b0, 8'd4);
      // Round counter saturation.
      for (int n = 5; n <= 260; n++) begin
         rc = (n > 255) ? 255 : n;
         add(8'd21, 1'b0, 1'b0, LD, 1'b1, 1'b1, 1'b0, 8'(rc));
         add_load_tail(8'(rc));
         add(8'd0, 1'b0, 1'b1, GO, 1'b0, 1'b0, 1'b0, 8'(rc));
      end
      add(8'd21, 1'b0, 1'b0, LD, 1'b1, 1'b1, 1'b0, 8'd255);
      add(8'd21, 1'b0, 1'b0, LD, 1'b1, 1'b0, 1'b0, 8'd255);

      // Reset state while reset is held.
      repeat (3) @(negedge Clock);
      #1;
      n_cmp++;
      if ({outstate, loadplat, score_clr, game_run, round_cnt} !== 14'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %b, expected all zero",
                  {outstate, loadplat, score_clr, game_run, round_cnt});
      end
      @(negedge Clock);
      rst = 1'b0;

      foreach (vecs[i]) apply(vecs[i]);

      // Asynchronous reset in the middle of LOAD, key held through release.
      @(posedge Clock);
      #3;
      rst = 1'b1;
      Keycode = 8'd44;
      #1;
      n_cmp++;
      if ({outstate, loadplat, score_clr, game_run, round_cnt} !== 14'd0) begin
         n_fail++;
         $display("FAIL async_reset: got os=%b lp=%b sc=%b gr=%b rc=%0d, expected all zero",
                  outstate, loadplat, score_clr, game_run, round_cnt);
      end
      rst = 1'b0;
      apply(mk(8'd44, 1'b0, 1'b0, LD, 1'b1, 1'b1, 1'b0, 8'd1));
      for (int i = 0; i < 3; i++) apply(mk(8'd44, 1'b0, 1'b0, LD, 1'b1, 1'b0, 1'b0, 8'd1));
      for (int i = 0; i < 6; i++) apply(mk(8'd44, 1'b0, 1'b0, PL, 1'b0, 1'b0, 1'b1, 8'd1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
